// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver with frame-synchronised inputs,
// leading-zero suppression and PWM brightness. Every output is registered and
// shows the slot counter and digit index from the previous cycle.
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned COUNT_PERIOD = 100000,
    parameter int unsigned BRIGHT_BITS  = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [4*NUM_DIGITS-1:0]   val_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en_in,
    input  logic                      lz_blank_in,
    input  logic [BRIGHT_BITS-1:0]    brightness_in,
    output logic [6:0]                cat_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_out
);

    localparam int unsigned CNT_W  = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PROD_W = BRIGHT_BITS + 32;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(COUNT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] digit_idx;

    // Shadow copies of the inputs, updated only at frame boundaries
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;
    logic [BRIGHT_BITS-1:0]  sh_bright;

    logic                    slot_last;
    logic                    frame_last;
    logic [PROD_W-1:0]       on_prod;
    logic [PROD_W-1:0]       on_time;
    logic                    lit;
    logic [3:0]              nibble;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              cat_next;
    logic                    dp_next;
    logic                    frame_next;

    // Hex digit to active-high segment pattern (a on bit 0 .. g on bit 6)
    function automatic logic [6:0] glyph(input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Slot and frame boundary detection
    always_comb begin
        slot_last  = (slot_cnt == SLOT_LAST);
        frame_last = slot_last && (digit_idx == IDX_LAST);
    end

    // Slot counter and digit index; a disabled digit still consumes its slot
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_last) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // Capture inputs on the last cycle of a frame so a frame is never torn
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
        end else if (frame_last) begin
            sh_val    <= val_in;
            sh_dp     <= dp_in;
            sh_en     <= digit_en_in;
            sh_lz     <= lz_blank_in;
            sh_bright <= brightness_in;
        end
    end

    // PWM window: lit while slot counter is below the scaled on-time
    always_comb begin
        on_prod = (PROD_W'(sh_bright) + PROD_W'(1)) * PROD_W'(COUNT_PERIOD);
        on_time = on_prod >> BRIGHT_BITS;
        lit     = sh_en[digit_idx] && (PROD_W'(slot_cnt) < on_time);
        nibble  = sh_val[{digit_idx, 2'b00} +: 4];
    end

    // Leading-zero mask: digit i is blankable when it and all higher nibbles are zero
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (sh_val[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_mask[i] = zero_run;
            end
        end
    end

    // Next output values; everything dark outside the lit window to avoid ghosting
    always_comb begin
        an_next    = '1;
        cat_next   = 7'h7F;
        dp_next    = 1'b1;
        frame_next = (slot_cnt == '0) && (digit_idx == '0);
        if (lit) begin
            an_next[digit_idx] = 1'b0;
            cat_next = (sh_lz && lz_mask[digit_idx]) ? 7'h7F : ~glyph(nibble);
            dp_next  = ~sh_dp[digit_idx];
        end
    end

    // Output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            an_out    <= '1;
            cat_out   <= 7'h7F;
            dp_out    <= 1'b1;
            frame_out <= 1'b0;
        end else begin
            an_out    <= an_next;
            cat_out   <= cat_next;
            dp_out    <= dp_next;
            frame_out <= frame_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, COUNT_PERIOD=16,
// BRIGHT_BITS=4 (64-cycle frames, on-time = brightness+1 cycles per slot).
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int CP = 16;
    localparam int BB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] val = '0;
    logic [3:0]  dp  = '0;
    logic [3:0]  en  = '0;
    logic        lz  = 1'b0;
    logic [3:0]  br  = '0;
    logic [6:0]  cat;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;

    int tests = 0;
    int fails = 0;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .COUNT_PERIOD (CP),
        .BRIGHT_BITS  (BB)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .val_in        (val),
        .dp_in         (dp),
        .digit_en_in   (en),
        .lz_blank_in   (lz),
        .brightness_in (br),
        .cat_out       (cat),
        .dp_out        (dpo),
        .an_out        (an),
        .frame_out     (frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [3:0]  br;
        int          off;
        logic [3:0]  an;
        logic [6:0]  cat;
        logic        dpo;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next frame_out pulse, bounded
    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (frame !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (frame !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_frame: no frame_out within 200 cycles, got %b expected 1", frame);
        end
    endtask

    task automatic apply(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                         input logic l, input logic [3:0] b);
        val = v;
        dp  = d;
        en  = e;
        lz  = l;
        br  = b;
        // Second frame is guaranteed to use the new shadow values
        wait_frame();
        wait_frame();
    endtask

    // Count PWM shape errors and lit cycles over one full frame starting at offset 0
    task automatic pwm_frame(input int on_cycles, output int errs, output int lit_cnt);
        errs    = 0;
        lit_cnt = 0;
        for (int o = 0; o < 64; o++) begin
            if (an != 4'hF) lit_cnt++;
            if ((an != 4'hF) != ((o % 16) < on_cycles)) errs++;
            if (an == 4'hF && (cat != 7'h7F || dpo != 1'b1)) errs++;
            if (o < 63) step();
        end
    endtask

    initial begin
        int n;
        int errs;
        int lit_cnt;

        // Full brightness scan of 0x1234
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF,  0, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 15, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 16, 4'hD, 7'h30, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 33, 4'hB, 7'h24, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 63, 4'h7, 7'h79, 1'b1});
        // PWM brightness 3 (4 lit cycles) and 0 (1 lit cycle)
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h3,  3, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h3,  4, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h3, 19, 4'hD, 7'h30, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h3, 20, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h0,  0, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h0,  1, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h0, 4'hF, 1'b0, 4'h0, 48, 4'h7, 7'h79, 1'b1});
        // Leading-zero suppression
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 4'hF,  0, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 4'hF, 16, 4'hD, 7'h12, 1'b1});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 4'hF, 32, 4'hB, 7'h7F, 1'b1});
        vecs.push_back('{16'h0050, 4'h8, 4'hF, 1'b1, 4'hF, 48, 4'h7, 7'h7F, 1'b0});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b0, 4'hF, 48, 4'h7, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 4'hF,  0, 4'hE, 7'h40, 1'b1});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 4'hF, 16, 4'hD, 7'h7F, 1'b1});
        // Enables and decimal points
        vecs.push_back('{16'h1234, 4'h2, 4'h5, 1'b0, 4'hF,  0, 4'hE, 7'h19, 1'b1});
        vecs.push_back('{16'h1234, 4'h2, 4'h5, 1'b0, 4'hF, 16, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h2, 4'h5, 1'b0, 4'hF, 32, 4'hB, 7'h24, 1'b1});
        vecs.push_back('{16'h1234, 4'h2, 4'h5, 1'b0, 4'hF, 48, 4'hF, 7'h7F, 1'b1});
        vecs.push_back('{16'h1234, 4'h2, 4'hF, 1'b0, 4'hF, 16, 4'hD, 7'h30, 1'b0});
        vecs.push_back('{16'h1234, 4'h2, 4'hF, 1'b0, 4'hF,  0, 4'hE, 7'h19, 1'b1});
        // Remaining glyphs
        vecs.push_back('{16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF,  0, 4'hE, 7'h21, 1'b1});
        vecs.push_back('{16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF, 20, 4'hD, 7'h46, 1'b1});
        vecs.push_back('{16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF, 40, 4'hB, 7'h03, 1'b1});
        vecs.push_back('{16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF, 63, 4'h7, 7'h08, 1'b1});
        vecs.push_back('{16'hEF98, 4'h0, 4'hF, 1'b0, 4'hF,  0, 4'hE, 7'h00, 1'b1});
        vecs.push_back('{16'hEF98, 4'h0, 4'hF, 1'b0, 4'hF, 16, 4'hD, 7'h10, 1'b1});
        vecs.push_back('{16'hEF98, 4'h0, 4'hF, 1'b0, 4'hF, 32, 4'hB, 7'h0E, 1'b1});
        vecs.push_back('{16'hEF98, 4'h0, 4'hF, 1'b0, 4'hF, 48, 4'h7, 7'h06, 1'b1});
        vecs.push_back('{16'h5670, 4'h0, 4'hF, 1'b0, 4'hF, 16, 4'hD, 7'h78, 1'b1});
        vecs.push_back('{16'h5670, 4'h0, 4'hF, 1'b0, 4'hF, 32, 4'hB, 7'h02, 1'b1});

        // Reset state
        #12;
        check("reset_an", an, 4'hF);
        check("reset_cat", cat, 7'h7F);
        check("reset_dp", dpo, 1'b1);
        check("reset_frame", frame, 1'b0);

        // Startup: first frame blank, frame_out on first cycle and every 64 cycles
        val = 16'h1234;
        en  = 4'hF;
        br  = 4'hF;
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("startup_frame", frame, 1'b1);
        errs = 0;
        for (int i = 0; i < 63; i++) begin
            if (an != 4'hF || cat != 7'h7F || dpo != 1'b1) errs++;
            step();
            if (frame != 1'b0) errs++;
        end
        if (an != 4'hF) errs++;
        check("first_frame_blank", errs, 0);
        step();
        check("frame2_frame", frame, 1'b1);
        check("frame2_an", an, 4'hE);
        check("frame2_cat", cat, 7'h19);
        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 200);
        check("frame_period", n, 64);

        // Asynchronous reset in the middle of a lit slot
        repeat (3) step();
        check("pre_reset_an", an, 4'hE);
        #2 rst = 1'b1;
        #1;
        check("async_reset_an", an, 4'hF);
        check("async_reset_cat", cat, 7'h7F);
        check("async_reset_frame", frame, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("restart_frame", frame, 1'b1);
        check("restart_blank", an, 4'hF);
        repeat (64) step();
        check("restart_period", frame, 1'b1);

        // Table-driven vectors
        foreach (vecs[k]) begin
            apply(vecs[k].val, vecs[k].dp, vecs[k].en, vecs[k].lz, vecs[k].br);
            repeat (vecs[k].off) step();
            check($sformatf("vec%0d_an", k), an, vecs[k].an);
            check($sformatf("vec%0d_cat", k), cat, vecs[k].cat);
            check($sformatf("vec%0d_dp", k), dpo, vecs[k].dpo);
        end

        // PWM shape over a whole frame
        apply(16'h1234, 4'h0, 4'hF, 1'b0, 4'h3);
        pwm_frame(4, errs, lit_cnt);
        check("pwm3_shape", errs, 0);
        check("pwm3_lit", lit_cnt, 16);
        apply(16'h1234, 4'h0, 4'hF, 1'b0, 4'h0);
        pwm_frame(1, errs, lit_cnt);
        check("pwm0_shape", errs, 0);
        check("pwm0_lit", lit_cnt, 4);

        // Enables and dp over a whole frame: digits 1 and 3 never lit, dp never low
        apply(16'h1234, 4'h2, 4'h5, 1'b0, 4'hF);
        errs = 0;
        for (int o = 0; o < 64; o++) begin
            if (an[1] == 1'b0 || an[3] == 1'b0 || dpo == 1'b0) errs++;
            step();
        end
        check("en_dp_frame", errs, 0);

        // Frame synchronisation: mid-frame change is invisible until the next frame
        apply(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF);
        repeat (32) step();
        check("sync_d2_old", cat, 7'h79);
        val = 16'h2222;
        repeat (16) step();
        check("sync_d3_old_an", an, 4'h7);
        check("sync_d3_old", cat, 7'h79);
        wait_frame();
        check("sync_d0_new", cat, 7'h24);
        repeat (48) step();
        check("sync_d3_new", cat, 7'h24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
